// File: rtl/id_ex_pkg.sv
// Shared encodings for the ID/EX stage: destination select, write-back source,
// EX opcode constants and the load-use bubble FSM states.
package id_ex_pkg;

    localparam logic [1:0] REGDST_RD   = 2'd0;
    localparam logic [1:0] REGDST_RT   = 2'd1;
    localparam logic [1:0] REGDST_FD   = 2'd2;
    localparam logic [1:0] REGDST_LINK = 2'd3;

    localparam logic [2:0] WBSRC_ALU = 3'd0;
    localparam logic [2:0] WBSRC_MEM = 3'd1;
    localparam logic [2:0] WBSRC_LUI = 3'd2;
    localparam logic [2:0] WBSRC_PC4 = 3'd3;

    // FR/FI format: rs field names an FP register rather than an integer one.
    localparam logic [2:0] EXOP_FP = 3'b111;

    typedef enum logic [1:0] {
        RUN = 2'd0,
        B1  = 2'd1,
        B2  = 2'd2
    } hz_state_t;

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use hazard detector and bubble FSM: one bubble after an integer/word load,
// two after a double-word FP load. stall_fd is combinational; state is registered.
module id_ex_hazard
    import id_ex_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              Float,
    input  logic [2:0]        ExOp,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              ex_valid,
    input  logic              ex_RegWrite,
    input  logic              ex_Float,
    input  logic              ex_DW,
    input  logic [2:0]        ex_WBSrc,
    input  logic [REG_AW-1:0] ex_dest,
    output logic              stall_fd,
    output logic              insert_bubble
);

    hz_state_t         state;
    logic              ex_load;
    logic              rs_fp;
    logic              rs_hit;
    logic              rt_hit;
    logic              hazard;
    logic [REG_AW-1:0] dest_hi;

    // Integer r0 is hard-wired, so a write to it can never create a dependency.
    function automatic logic reg_hit(input logic src_fp, input logic [REG_AW-1:0] src,
                                     input logic dst_fp, input logic [REG_AW-1:0] dst);
        return (src_fp == dst_fp) && (src == dst) && (src_fp || (src != '0));
    endfunction

    always_comb begin
        dest_hi = ex_dest + REG_AW'(1);
        ex_load = ex_valid & ex_RegWrite & (ex_WBSrc == WBSRC_MEM);
        rs_fp   = Float & (ExOp == EXOP_FP);
        rs_hit  = reg_hit(rs_fp, rs, ex_Float, ex_dest)
                | (ex_DW & reg_hit(rs_fp, rs, ex_Float, dest_hi));
        rt_hit  = reg_hit(Float, rt, ex_Float, ex_dest)
                | (ex_DW & reg_hit(Float, rt, ex_Float, dest_hi));
        hazard  = (state == RUN) & ex_load & (rs_hit | rt_hit);
        stall_fd      = hazard | (state == B2);
        insert_bubble = stall_fd | flush;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN:     if (hazard) state <= ex_DW ? B2 : B1;
                B2:      state <= B1;
                B1:      state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register, 1-cycle latency; bubbles replace the incoming
// instruction on flush or load-use stall, and stall_fd holds fetch/decode.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              JR,
    input  logic              Byte,
    input  logic              Jump,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              Float,
    input  logic              Shift,
    input  logic              DW,
    input  logic [1:0]        RegDst,
    input  logic [2:0]        WBSrc,
    input  logic [2:0]        ExOp,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] sh,
    input  logic [5:0]        fun,
    input  logic [15:0]       imm,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] pc_plus4,
    output logic              stall_fd,
    output logic              ex_JR,
    output logic              ex_Byte,
    output logic              ex_Jump,
    output logic              ex_MemWrite,
    output logic              ex_RegWrite,
    output logic              ex_Float,
    output logic              ex_Shift,
    output logic              ex_DW,
    output logic [1:0]        ex_RegDst,
    output logic [2:0]        ex_WBSrc,
    output logic [2:0]        ex_ExOp,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] ex_sh,
    output logic [5:0]        ex_fun,
    output logic [15:0]       ex_imm,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_valid
);

    logic              insert_bubble;
    logic [REG_AW-1:0] dest;

    id_ex_hazard #(.REG_AW(REG_AW)) u_hazard (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .Float         (Float),
        .ExOp          (ExOp),
        .rs            (rs),
        .rt            (rt),
        .ex_valid      (ex_valid),
        .ex_RegWrite   (ex_RegWrite),
        .ex_Float      (ex_Float),
        .ex_DW         (ex_DW),
        .ex_WBSrc      (ex_WBSrc),
        .ex_dest       (ex_dest),
        .stall_fd      (stall_fd),
        .insert_bubble (insert_bubble)
    );

    always_comb begin
        unique case (RegDst)
            REGDST_RD: dest = rd;
            REGDST_RT: dest = rt;
            REGDST_FD: dest = sh;
            default:   dest = REG_AW'(LINK_REG);
        endcase
    end

    // Data fields follow the inputs even on a bubble; only the control side is squashed.
    always_ff @(posedge clk) begin
        if (rst) begin
            {ex_JR, ex_Byte, ex_Jump, ex_MemWrite, ex_RegWrite, ex_Float, ex_Shift, ex_DW} <= '0;
            ex_RegDst   <= '0;
            ex_WBSrc    <= '0;
            ex_ExOp     <= '0;
            ex_dest     <= '0;
            ex_valid    <= 1'b0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_sh       <= '0;
            ex_fun      <= '0;
            ex_imm      <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_pc_plus4 <= '0;
        end else begin
            ex_rs       <= rs;
            ex_rt       <= rt;
            ex_rd       <= rd;
            ex_sh       <= sh;
            ex_fun      <= fun;
            ex_imm      <= imm;
            ex_rs_data  <= rs_data;
            ex_rt_data  <= rt_data;
            ex_pc_plus4 <= pc_plus4;
            if (insert_bubble) begin
                {ex_JR, ex_Byte, ex_Jump, ex_MemWrite, ex_RegWrite, ex_Float, ex_Shift, ex_DW} <= '0;
                ex_RegDst <= '0;
                ex_WBSrc  <= '0;
                ex_ExOp   <= '0;
                ex_dest   <= '0;
                ex_valid  <= 1'b0;
            end else begin
                {ex_JR, ex_Byte, ex_Jump, ex_MemWrite, ex_RegWrite, ex_Float, ex_Shift, ex_DW}
                    <= {JR, Byte, Jump, MemWrite, RegWrite, Float, Shift, DW};
                ex_RegDst <= RegDst;
                ex_WBSrc  <= WBSrc;
                ex_ExOp   <= ExOp;
                ex_dest   <= dest;
                ex_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed load-use/flush/jal scenarios followed by randomized traffic, all
// checked against a pending-bubble-count reference model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        rst, flush, JR, Byte, Jump, MemWrite, RegWrite, Float, Shift, DW;
        logic [1:0]  RegDst;
        logic [2:0]  WBSrc, ExOp;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fun;
        logic [15:0] imm;
        logic [31:0] rs_data, rt_data, pc_plus4;
    } in_t;

    logic clk = 1'b0;
    logic rst, flush, JR, Byte, Jump, MemWrite, RegWrite, Float, Shift, DW;
    logic [1:0]  RegDst;
    logic [2:0]  WBSrc, ExOp;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fun;
    logic [15:0] imm;
    logic [31:0] rs_data, rt_data, pc_plus4;
    logic        stall_fd;
    logic        ex_JR, ex_Byte, ex_Jump, ex_MemWrite, ex_RegWrite, ex_Float, ex_Shift, ex_DW;
    logic [1:0]  ex_RegDst;
    logic [2:0]  ex_WBSrc, ex_ExOp;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_sh, ex_dest;
    logic [5:0]  ex_fun;
    logic [15:0] ex_imm;
    logic [31:0] ex_rs_data, ex_rt_data, ex_pc_plus4;
    logic        ex_valid;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .JR(JR), .Byte(Byte), .Jump(Jump),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .Float(Float), .Shift(Shift), .DW(DW),
        .RegDst(RegDst), .WBSrc(WBSrc), .ExOp(ExOp), .rs(rs), .rt(rt), .rd(rd), .sh(sh),
        .fun(fun), .imm(imm), .rs_data(rs_data), .rt_data(rt_data), .pc_plus4(pc_plus4),
        .stall_fd(stall_fd), .ex_JR(ex_JR), .ex_Byte(ex_Byte), .ex_Jump(ex_Jump),
        .ex_MemWrite(ex_MemWrite), .ex_RegWrite(ex_RegWrite), .ex_Float(ex_Float),
        .ex_Shift(ex_Shift), .ex_DW(ex_DW), .ex_RegDst(ex_RegDst), .ex_WBSrc(ex_WBSrc),
        .ex_ExOp(ex_ExOp), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_sh(ex_sh),
        .ex_fun(ex_fun), .ex_imm(ex_imm), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_pc_plus4(ex_pc_plus4), .ex_dest(ex_dest), .ex_valid(ex_valid)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    bit   started  = 0;
    logic last_stall;

    // Reference model: what EX holds and how many further forced stalls remain.
    in_t        m_ex;
    bit         m_valid   = 0;
    logic [4:0] m_dest    = '0;
    int         m_pending = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] flags_of(input in_t v);
        return {v.JR, v.Byte, v.Jump, v.MemWrite, v.RegWrite, v.Float, v.Shift, v.DW,
                v.RegDst, v.WBSrc, v.ExOp};
    endfunction

    function automatic logic [4:0] dest_of(input in_t v);
        case (v.RegDst)
            2'd0:    return v.rd;
            2'd1:    return v.rt;
            2'd2:    return v.sh;
            default: return 5'd31;
        endcase
    endfunction

    // Registers numbered in one space: 0..31 integer, 32..63 floating point.
    function automatic int reg_id(input bit fp, input logic [4:0] n);
        return (fp ? 32 : 0) + int'(n);
    endfunction

    function automatic bit model_hazard(input in_t v);
        int d0, d1, s_rs, s_rt;
        if (!(m_valid && m_ex.RegWrite && m_ex.WBSrc == 3'd1)) return 0;
        d0   = reg_id(m_ex.Float, m_dest);
        d1   = m_ex.DW ? reg_id(m_ex.Float, 5'((int'(m_dest) + 1) % 32)) : -1;
        s_rs = reg_id(v.Float && v.ExOp == 3'b111, v.rs);
        s_rt = reg_id(v.Float, v.rt);
        return (s_rs != 0 && (s_rs == d0 || s_rs == d1)) ||
               (s_rt != 0 && (s_rt == d0 || s_rt == d1));
    endfunction

    task automatic drive(input in_t v);
        rst = v.rst; flush = v.flush; JR = v.JR; Byte = v.Byte; Jump = v.Jump;
        MemWrite = v.MemWrite; RegWrite = v.RegWrite; Float = v.Float; Shift = v.Shift;
        DW = v.DW; RegDst = v.RegDst; WBSrc = v.WBSrc; ExOp = v.ExOp; rs = v.rs; rt = v.rt;
        rd = v.rd; sh = v.sh; fun = v.fun; imm = v.imm; rs_data = v.rs_data;
        rt_data = v.rt_data; pc_plus4 = v.pc_plus4;
    endtask

    task automatic step(input in_t v, input string tag);
        bit exp_stall;
        drive(v);
        #1;
        exp_stall  = (m_pending > 0) || model_hazard(v);
        last_stall = stall_fd;
        if (started && !v.rst) chk({tag, "_stall"}, stall_fd, exp_stall);
        @(posedge clk);
        if (v.rst) begin
            m_ex = '0; m_valid = 0; m_dest = '0; m_pending = 0; started = 1;
        end else if (v.flush) begin
            m_valid = 0; m_pending = 0;
        end else if (exp_stall) begin
            if (m_pending > 0) m_pending--;
            else if (m_ex.DW) m_pending = 1;
            m_valid = 0;
        end else begin
            m_ex = v; m_valid = 1; m_dest = dest_of(v);
        end
        #1;
        chk({tag, "_valid"}, ex_valid, m_valid);
        chk({tag, "_flags"},
            {ex_JR, ex_Byte, ex_Jump, ex_MemWrite, ex_RegWrite, ex_Float, ex_Shift, ex_DW,
             ex_RegDst, ex_WBSrc, ex_ExOp}, m_valid ? flags_of(m_ex) : 16'h0);
        if (m_valid) begin
            chk({tag, "_dest"}, ex_dest, m_dest);
            chk({tag, "_fields"}, {ex_rs, ex_rt, ex_rd, ex_sh, ex_fun, ex_imm},
                {m_ex.rs, m_ex.rt, m_ex.rd, m_ex.sh, m_ex.fun, m_ex.imm});
            chk({tag, "_data"}, {ex_rs_data, ex_rt_data}, {m_ex.rs_data, m_ex.rt_data});
            chk({tag, "_pc4"}, ex_pc_plus4, m_ex.pc_plus4);
        end
    endtask

    function automatic in_t rand_in();
        in_t v;
        v          = '0;
        v.rst      = ($urandom_range(0, 39) == 0);
        v.flush    = ($urandom_range(0, 9) == 0);
        {v.JR, v.Byte, v.Jump, v.MemWrite, v.RegWrite, v.Float, v.Shift, v.DW} = 8'($urandom);
        v.RegDst   = 2'($urandom);
        v.WBSrc    = $urandom_range(0, 1) ? 3'd1 : 3'($urandom);
        v.ExOp     = $urandom_range(0, 1) ? 3'b111 : 3'($urandom);
        v.rs       = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 3));
        v.rt       = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'($urandom_range(0, 3));
        v.rd       = 5'($urandom_range(0, 3));
        v.sh       = 5'($urandom_range(0, 3));
        v.fun      = 6'($urandom);
        v.imm      = 16'($urandom);
        v.rs_data  = $urandom;
        v.rt_data  = $urandom;
        v.pc_plus4 = $urandom;
        return v;
    endfunction

    in_t lw, add, ldc1, addd, v;

    initial begin
        // 1: reset with random inputs
        v = rand_in(); v.rst = 1; step(v, "rst0");
        v = rand_in(); v.rst = 1; step(v, "rst1");
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_dest", ex_dest, 5'd0);
        chk("rst_pc4", ex_pc_plus4, 32'd0);
        chk("rst_stall", stall_fd, 1'b0);

        // 2: lw r5 then add using r5 -> one bubble
        lw = '0; lw.RegWrite = 1; lw.WBSrc = 3'd1; lw.RegDst = 2'd1; lw.rs = 5'd1; lw.rt = 5'd5;
        add = '0; add.RegWrite = 1; add.rs = 5'd5; add.rt = 5'd6; add.rd = 5'd7;
        add.fun = 6'h20; add.rs_data = 32'h1234; add.pc_plus4 = 32'h0040_0010;
        step(lw, "t2_lw");
        step(add, "t2_add_stall");
        chk("t2_stall_hi", last_stall, 1'b1);
        chk("t2_bubble", ex_valid, 1'b0);
        step(add, "t2_add_go");
        chk("t2_stall_lo", last_stall, 1'b0);
        chk("t2_add_valid", ex_valid, 1'b1);
        chk("t2_add_dest", ex_dest, 5'd7);

        // 3: ldc1 f4 then add.d reading f5 (upper half) -> two bubbles
        ldc1 = '0; ldc1.Float = 1; ldc1.DW = 1; ldc1.RegWrite = 1; ldc1.WBSrc = 3'd1;
        ldc1.RegDst = 2'd1; ldc1.rs = 5'd2; ldc1.rt = 5'd4;
        addd = '0; addd.Float = 1; addd.ExOp = 3'b111; addd.RegWrite = 1; addd.RegDst = 2'd2;
        addd.rs = 5'd5; addd.rt = 5'd8; addd.sh = 5'd6;
        step(ldc1, "t3_ldc1");
        step(addd, "t3_s1");
        chk("t3_stall1", last_stall, 1'b1);
        step(addd, "t3_s2");
        chk("t3_stall2", last_stall, 1'b1);
        chk("t3_bubble2", ex_valid, 1'b0);
        step(addd, "t3_go");
        chk("t3_stall_lo", last_stall, 1'b0);
        chk("t3_dest", ex_dest, 5'd6);

        // 4: r0 never stalls; an int load never blocks an FP source of the same number
        v = lw; v.rt = 5'd0; step(v, "t4_lw0");
        v = add; v.rs = 5'd0; v.rt = 5'd0; step(v, "t4_add0");
        chk("t4_r0_nostall", last_stall, 1'b0);
        v = lw; v.rt = 5'd3; step(v, "t4_lw3");
        v = addd; v.rs = 5'd3; v.rt = 5'd9; step(v, "t4_fp3");
        chk("t4_file_nostall", last_stall, 1'b0);

        // 5: flush while in the second-bubble state
        step(ldc1, "t5_ldc1");
        step(addd, "t5_s1");
        v = addd; v.flush = 1; step(v, "t5_flush");
        chk("t5_flush_stall", last_stall, 1'b1);
        chk("t5_flush_bubble", ex_valid, 1'b0);
        step(add, "t5_next");
        chk("t5_next_nostall", last_stall, 1'b0);
        chk("t5_next_valid", ex_valid, 1'b1);

        // 6: jal writes the link register
        v = '0; v.Jump = 1; v.RegWrite = 1; v.RegDst = 2'd3; v.WBSrc = 3'd3;
        v.rd = 5'd2; v.pc_plus4 = 32'h0040_0008;
        step(v, "t6_jal");
        chk("t6_dest", ex_dest, 5'd31);
        chk("t6_jump", ex_Jump, 1'b1);
        chk("t6_pc4", ex_pc_plus4, 32'h0040_0008);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            v = rand_in();
            step(v, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
